// File: rtl/cra_pkg.sv
// Shared types and defaults for the CRAM address sequencer:
// skip-condition and dispatch-select encodings as carried in the microword.
package cra_pkg;

  localparam int ADR_W_DEF       = 11;
  localparam int STACK_DEPTH_DEF = 16;

  typedef enum logic [2:0] {
    SKIP_NONE  = 3'd0,
    SKIP_AD0   = 3'd1,
    SKIP_EQ0   = 3'd2,
    SKIP_CRY0  = 3'd3,
    SKIP_NAD0  = 3'd4,
    SKIP_NEQ0  = 3'd5,
    SKIP_EXT   = 3'd6,
    SKIP_NONE7 = 3'd7
  } skip_t;

  typedef enum logic [1:0] {
    DISP_J    = 2'd0,
    DISP_DRAM = 2'd1,
    DISP_MUL  = 2'd2,
    DISP_RET  = 2'd3
  } disp_t;

  function automatic logic skip_eval(skip_t sel, logic ad00, logic ad_eq0,
                                     logic ad_cry0, logic skip_ext);
    logic r;
    r = 1'b0;
    case (sel)
      SKIP_AD0:  r = ad00;
      SKIP_EQ0:  r = ad_eq0;
      SKIP_CRY0: r = ad_cry0;
      SKIP_NAD0: r = ~ad00;
      SKIP_NEQ0: r = ~ad_eq0;
      SKIP_EXT:  r = skip_ext;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cra_seq_if.sv
// Microword, EDP-condition and status bundle between the microcode control
// path (master) and the address sequencer (slave).
interface cra_seq_if #(
  parameter int ADR_W       = cra_pkg::ADR_W_DEF,
  parameter int STACK_DEPTH = cra_pkg::STACK_DEPTH_DEF
);
  import cra_pkg::*;

  logic                           hold;
  logic [ADR_W-1:0]               cramJ;
  skip_t                          cramSkip;
  disp_t                          cramDisp;
  logic                           cramCall;
  logic [ADR_W-1:0]               dramJ;
  logic [3:0]                     dispData;
  logic                           ad00;
  logic                           adEq0;
  logic                           adCry0;
  logic                           skipExt;
  logic                           clrErr;
  logic [ADR_W-1:0]               nextAdr;
  logic [ADR_W-1:0]               cramAdr;
  logic [$clog2(STACK_DEPTH):0]   stackDepth;
  logic                           ovfErr;
  logic                           unfErr;

  modport master (
    output hold, cramJ, cramSkip, cramDisp, cramCall, dramJ, dispData,
           ad00, adEq0, adCry0, skipExt, clrErr,
    input  nextAdr, cramAdr, stackDepth, ovfErr, unfErr
  );

  modport slave (
    input  hold, cramJ, cramSkip, cramDisp, cramCall, dramJ, dispData,
           ad00, adEq0, adCry0, skipExt, clrErr,
    output nextAdr, cramAdr, stackDepth, ovfErr, unfErr
  );

endinterface

// File: rtl/cra_stack.sv
// Return-address LIFO. Callers only issue legal requests; replace overwrites
// the current top in place so a call and a return can share one cycle.
module cra_stack #(
  parameter int W     = 11,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       replace,
  input  logic [W-1:0]               wr_data,
  output logic [W-1:0]               top,
  output logic [$clog2(DEPTH):0]     depth,
  output logic                       full,
  output logic                       empty
);

  localparam int IDX_W   = $clog2(DEPTH);
  localparam int DEPTH_W = IDX_W + 1;

  logic [W-1:0]       mem_q [DEPTH];
  logic [W-1:0]       mem_d [DEPTH];
  logic [DEPTH_W-1:0] depth_q;
  logic [DEPTH_W-1:0] depth_d;
  logic [IDX_W-1:0]   top_idx;
  logic [IDX_W-1:0]   push_idx;

  always_comb begin
    top_idx  = IDX_W'(depth_q - 1'b1);
    push_idx = depth_q[IDX_W-1:0];
    full     = (depth_q == DEPTH_W'(DEPTH));
    empty    = (depth_q == '0);
    top      = empty ? '0 : mem_q[top_idx];
    depth    = depth_q;
  end

  always_comb begin
    mem_d   = mem_q;
    depth_d = depth_q;
    if (replace) begin
      mem_d[top_idx] = wr_data;
    end else if (push) begin
      mem_d[push_idx] = wr_data;
      depth_d         = depth_q + 1'b1;
    end else if (pop) begin
      depth_d = depth_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) depth_q <= '0;
    else       depth_q <= depth_d;
  end

  // Contents are meaningless once depth is cleared, so storage has no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/cra_seq.sv
// Microcode address sequencer: J/DRAM/multiway/return dispatch with skip,
// call/return stack, MBOX hold and sticky stack error flags.
module cra_seq
  import cra_pkg::*;
#(
  parameter int ADR_W       = ADR_W_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        reset,
  cra_seq_if.slave    bus
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH) + 1;

  logic [ADR_W-1:0]   cram_adr_q;
  logic [ADR_W-1:0]   cram_adr_d;
  logic               ovf_err_q;
  logic               ovf_err_d;
  logic               unf_err_q;
  logic               unf_err_d;
  logic [ADR_W-1:0]   base_adr;
  logic [ADR_W-1:0]   next_adr;
  logic [ADR_W-1:0]   push_adr;
  logic [ADR_W-1:0]   stk_top;
  logic [DEPTH_W-1:0] stk_depth;
  logic               stk_full;
  logic               stk_empty;
  logic               stk_push;
  logic               stk_pop;
  logic               stk_replace;
  logic               skip_true;
  logic               is_ret;
  logic               is_call;
  logic               ovf_set;
  logic               unf_set;

  cra_stack #(
    .W     (ADR_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk     (clk),
    .reset   (reset),
    .push    (stk_push),
    .pop     (stk_pop),
    .replace (stk_replace),
    .wr_data (push_adr),
    .top     (stk_top),
    .depth   (stk_depth),
    .full    (stk_full),
    .empty   (stk_empty)
  );

  // An empty stack presents top=0, so an underflowing return falls back to cramJ.
  always_comb begin
    skip_true = skip_eval(bus.cramSkip, bus.ad00, bus.adEq0, bus.adCry0, bus.skipExt);
    base_adr  = bus.cramJ;
    case (bus.cramDisp)
      DISP_J:    base_adr = bus.cramJ;
      DISP_DRAM: base_adr = bus.dramJ;
      DISP_MUL:  base_adr = bus.cramJ | {{(ADR_W-4){1'b0}}, bus.dispData};
      DISP_RET:  base_adr = stk_top | bus.cramJ;
      default:   base_adr = bus.cramJ;
    endcase
    next_adr = base_adr | {{(ADR_W-1){1'b0}}, skip_true};
  end

  always_comb begin
    is_ret      = (bus.cramDisp == DISP_RET);
    is_call     = bus.cramCall;
    push_adr    = cram_adr_q + 1'b1;
    stk_replace = ~bus.hold & is_call & is_ret & ~stk_empty;
    stk_push    = ~bus.hold & is_call & ~(is_ret & ~stk_empty) & ~stk_full;
    stk_pop     = ~bus.hold & is_ret & ~is_call & ~stk_empty;
    ovf_set     = is_call & ~(is_ret & ~stk_empty) & stk_full;
    unf_set     = is_ret & stk_empty;
  end

  // A new error wins over clrErr in the same cycle.
  always_comb begin
    cram_adr_d = cram_adr_q;
    ovf_err_d  = ovf_err_q;
    unf_err_d  = unf_err_q;
    if (!bus.hold) begin
      cram_adr_d = next_adr;
      ovf_err_d  = ovf_set | (ovf_err_q & ~bus.clrErr);
      unf_err_d  = unf_set | (unf_err_q & ~bus.clrErr);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cram_adr_q <= '0;
      ovf_err_q  <= 1'b0;
      unf_err_q  <= 1'b0;
    end else begin
      cram_adr_q <= cram_adr_d;
      ovf_err_q  <= ovf_err_d;
      unf_err_q  <= unf_err_d;
    end
  end

  assign bus.nextAdr    = next_adr;
  assign bus.cramAdr    = cram_adr_q;
  assign bus.stackDepth = stk_depth;
  assign bus.ovfErr     = ovf_err_q;
  assign bus.unfErr     = unf_err_q;

endmodule

// File: tb/tb_cra_seq.sv
// Directed-vector bench for cra_seq: sequencing, skips, dispatch, call/return,
// stack overflow/underflow, hold and reset-during-hold.
module tb_cra_seq;
  import cra_pkg::*;

  logic clk;
  logic reset;
  int   assertCount;
  int   failCount;

  cra_seq_if #(.ADR_W(11), .STACK_DEPTH(16)) bus();

  cra_seq #(.ADR_W(11), .STACK_DEPTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [10:0] j, input skip_t skip,
                               input disp_t disp, input logic call);
    bus.cramJ    = j;
    bus.cramSkip = skip;
    bus.cramDisp = disp;
    bus.cramCall = call;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkState(input string tag, input logic [10:0] adr,
                            input int depth, input logic ovf, input logic unf);
    checkOutput({tag, ".adr"},   32'(bus.cramAdr),    32'(adr));
    checkOutput({tag, ".depth"}, 32'(bus.stackDepth), 32'(depth));
    checkOutput({tag, ".ovf"},   32'(bus.ovfErr),     32'(ovf));
    checkOutput({tag, ".unf"},   32'(bus.unfErr),     32'(unf));
  endtask

  initial begin
    logic [10:0] expRet;
    assertCount  = 0;
    failCount    = 0;
    reset        = 1'b1;
    bus.hold     = 1'b0;
    bus.dramJ    = '0;
    bus.dispData = '0;
    bus.ad00     = 1'b0;
    bus.adEq0    = 1'b0;
    bus.adCry0   = 1'b0;
    bus.skipExt  = 1'b0;
    bus.clrErr   = 1'b0;
    applyStimulus(11'h010, SKIP_NONE, DISP_J, 1'b0);
    tick();
    tick();
    checkState("reset", 11'h000, 0, 1'b0, 1'b0);
    reset = 1'b0;

    // J chain
    checkOutput("j1.next", 32'(bus.nextAdr), 32'h010);
    tick();
    checkOutput("j1.adr", 32'(bus.cramAdr), 32'h010);
    applyStimulus(11'h020, SKIP_NONE, DISP_J, 1'b0);
    tick();
    checkOutput("j2.adr", 32'(bus.cramAdr), 32'h020);

    // Skip conditions
    bus.adEq0 = 1'b1;
    applyStimulus(11'h100, SKIP_EQ0, DISP_J, 1'b0);
    checkOutput("skip.eq0", 32'(bus.nextAdr), 32'h101);
    applyStimulus(11'h100, SKIP_NEQ0, DISP_J, 1'b0);
    checkOutput("skip.neq0", 32'(bus.nextAdr), 32'h100);
    bus.ad00 = 1'b1;
    applyStimulus(11'h100, SKIP_AD0, DISP_J, 1'b0);
    checkOutput("skip.ad0", 32'(bus.nextAdr), 32'h101);
    applyStimulus(11'h100, SKIP_NAD0, DISP_J, 1'b0);
    checkOutput("skip.nad0", 32'(bus.nextAdr), 32'h100);
    bus.adCry0 = 1'b1;
    applyStimulus(11'h100, SKIP_CRY0, DISP_J, 1'b0);
    checkOutput("skip.cry0", 32'(bus.nextAdr), 32'h101);
    bus.skipExt = 1'b1;
    applyStimulus(11'h100, SKIP_EXT, DISP_J, 1'b0);
    checkOutput("skip.ext", 32'(bus.nextAdr), 32'h101);
    applyStimulus(11'h100, SKIP_NONE7, DISP_J, 1'b0);
    checkOutput("skip.none7", 32'(bus.nextAdr), 32'h100);
    applyStimulus(11'h100, SKIP_EQ0, DISP_J, 1'b0);
    tick();
    checkOutput("skip.adr", 32'(bus.cramAdr), 32'h101);
    bus.ad00 = 1'b0; bus.adEq0 = 1'b0; bus.adCry0 = 1'b0; bus.skipExt = 1'b0;

    // Multiway and DRAM dispatch
    bus.dispData = 4'hA;
    applyStimulus(11'h200, SKIP_NONE, DISP_MUL, 1'b0);
    checkOutput("mul.next", 32'(bus.nextAdr), 32'h20A);
    tick();
    checkOutput("mul.adr", 32'(bus.cramAdr), 32'h20A);
    bus.dramJ = 11'h345;
    applyStimulus(11'h000, SKIP_NONE, DISP_DRAM, 1'b0);
    tick();
    checkOutput("dram.adr", 32'(bus.cramAdr), 32'h345);

    // Call and return, plain and skip-return
    applyStimulus(11'h050, SKIP_NONE, DISP_J, 1'b0);
    tick();
    applyStimulus(11'h300, SKIP_NONE, DISP_J, 1'b1);
    tick();
    checkState("call1", 11'h300, 1, 1'b0, 1'b0);
    applyStimulus(11'h000, SKIP_NONE, DISP_RET, 1'b0);
    checkOutput("ret1.next", 32'(bus.nextAdr), 32'h051);
    tick();
    checkState("ret1", 11'h051, 0, 1'b0, 1'b0);
    applyStimulus(11'h300, SKIP_NONE, DISP_J, 1'b1);
    tick();
    checkOutput("call2.depth", 32'(bus.stackDepth), 32'd1);
    applyStimulus(11'h001, SKIP_NONE, DISP_RET, 1'b0);
    checkOutput("ret2.next", 32'(bus.nextAdr), 32'h053);
    tick();
    checkState("ret2", 11'h053, 0, 1'b0, 1'b0);

    // Overflow: 17 nested calls
    for (int i = 0; i < 17; i++) begin
      applyStimulus(11'h400 + 11'(i), SKIP_NONE, DISP_J, 1'b1);
      tick();
      if (i == 15) checkState("call16", 11'h40F, 16, 1'b0, 1'b0);
    end
    checkState("call17", 11'h410, 16, 1'b1, 1'b0);

    // Unwind, then underflow on the 17th return
    for (int k = 0; k < 16; k++) begin
      expRet = (k == 15) ? 11'h054 : 11'h400 + 11'(15 - k);
      applyStimulus(11'h000, SKIP_NONE, DISP_RET, 1'b0);
      checkOutput($sformatf("unwind%0d.next", k), 32'(bus.nextAdr), 32'(expRet));
      tick();
    end
    checkOutput("unwind.depth", 32'(bus.stackDepth), 32'd0);
    applyStimulus(11'h123, SKIP_NONE, DISP_RET, 1'b0);
    checkOutput("unf.next", 32'(bus.nextAdr), 32'h123);
    tick();
    checkState("unf", 11'h123, 0, 1'b1, 1'b1);
    bus.clrErr = 1'b1;
    applyStimulus(11'h600, SKIP_NONE, DISP_J, 1'b0);
    tick();
    bus.clrErr = 1'b0;
    checkState("clr", 11'h600, 0, 1'b0, 1'b0);

    // Combined call+return: replace when non-empty, push-only when empty
    applyStimulus(11'h610, SKIP_NONE, DISP_J, 1'b1);
    tick();
    applyStimulus(11'h000, SKIP_NONE, DISP_RET, 1'b1);
    checkOutput("cr.next", 32'(bus.nextAdr), 32'h601);
    tick();
    checkState("cr", 11'h601, 1, 1'b0, 1'b0);
    applyStimulus(11'h000, SKIP_NONE, DISP_RET, 1'b0);
    checkOutput("cr.ret.next", 32'(bus.nextAdr), 32'h611);
    tick();
    applyStimulus(11'h020, SKIP_NONE, DISP_RET, 1'b1);
    checkOutput("cr0.next", 32'(bus.nextAdr), 32'h020);
    tick();
    checkState("cr0", 11'h020, 1, 1'b0, 1'b1);
    applyStimulus(11'h030, SKIP_NONE, DISP_RET, 1'b0);
    checkOutput("cr0.ret.next", 32'(bus.nextAdr), 32'h632);
    tick();
    bus.clrErr = 1'b1;
    applyStimulus(11'h040, SKIP_NONE, DISP_RET, 1'b0);
    tick();
    bus.clrErr = 1'b0;
    checkState("clrnew", 11'h040, 0, 1'b0, 1'b1);

    // Address wrap on call from 0x7FF
    applyStimulus(11'h7FF, SKIP_NONE, DISP_J, 1'b0);
    tick();
    applyStimulus(11'h100, SKIP_NONE, DISP_J, 1'b1);
    tick();
    applyStimulus(11'h000, SKIP_NONE, DISP_RET, 1'b0);
    checkOutput("wrap.next", 32'(bus.nextAdr), 32'h000);
    tick();

    // Hold freezes everything; reset overrides hold immediately
    applyStimulus(11'h700, SKIP_NONE, DISP_J, 1'b1);
    tick();
    bus.hold   = 1'b1;
    bus.clrErr = 1'b1;
    applyStimulus(11'h710, SKIP_NONE, DISP_J, 1'b1);
    checkOutput("hold.next", 32'(bus.nextAdr), 32'h710);
    for (int h = 0; h < 5; h++) begin
      tick();
      checkState($sformatf("hold%0d", h), 11'h700, 1, 1'b0, 1'b1);
    end
    reset = 1'b1;
    #1;
    checkState("holdrst", 11'h000, 0, 1'b0, 1'b0);
    tick();
    reset      = 1'b0;
    bus.hold   = 1'b0;
    bus.clrErr = 1'b0;
    applyStimulus(11'h020, SKIP_NONE, DISP_J, 1'b0);
    tick();
    checkState("post", 11'h020, 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
